object_square: RTL and testbench

// - Pixel-object generator for the 640x480 VGA display path.
// - From the current scan position (HCount/VCount) it decides whether the pixel lies

---
 rtl/object_square.sv | 65 ++++++
 tb/tb_object_square.sv | 118 +++++++++++
 2 files changed

// File: rtl/object_square.sv
// Square / full-screen object generator for a 640x480 VGA scan.
// Region membership and border-band flags are registered to line up with the RGB stage.
module object_square #(
    parameter int unsigned SQ_X     = 240,
    parameter int unsigned SQ_Y     = 40,
    parameter int unsigned SQ_SIZE  = 160,
    parameter int unsigned BORDER   = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] HCount,
    input  logic [9:0] VCount,
    input  logic       square_select,
    input  logic       full_screen,
    output logic       square_on,
    output logic       square_edge
);

    // 11-bit bounds so SQ_X + SQ_SIZE cannot wrap
    logic [10:0] x0, x1, y0, y1;
    logic [10:0] h_ext, v_ext;
    logic        active, in_rgn;
    logic        on_d, on_q;
    logic        edge_d, edge_q;

    always_comb begin
        h_ext = {1'b0, HCount};
        v_ext = {1'b0, VCount};
        if (full_screen) begin
            x0 = 11'd0;
            x1 = 11'(H_ACTIVE - 1);
            y0 = 11'd0;
            y1 = 11'(V_ACTIVE - 1);
        end else begin
            x0 = 11'(SQ_X);
            x1 = 11'(SQ_X + SQ_SIZE - 1);
            y0 = 11'(SQ_Y);
            y1 = 11'(SQ_Y + SQ_SIZE - 1);
        end
    end

    always_comb begin
        active = (h_ext < 11'(H_ACTIVE)) && (v_ext < 11'(V_ACTIVE));
        in_rgn = (h_ext >= x0) && (h_ext <= x1) && (v_ext >= y0) && (v_ext <= y1);
        on_d   = square_select && active && in_rgn;
        edge_d = on_d && ((h_ext < x0 + 11'(BORDER)) || (h_ext > x1 - 11'(BORDER)) ||
                          (v_ext < y0 + 11'(BORDER)) || (v_ext > y1 - 11'(BORDER)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            on_q   <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            on_q   <= on_d;
            edge_q <= edge_d;
        end
    end

    assign square_on   = on_q;
    assign square_edge = edge_q;

endmodule

// File: tb/tb_object_square.sv
// Directed bench for object_square: hand-computed on/edge values, latency and async reset.
module tb_object_square;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] HCount = '0;
    logic [9:0] VCount = '0;
    logic       square_select = 1'b0;
    logic       full_screen = 1'b0;
    logic       square_on;
    logic       square_edge;

    int n_cmp  = 0;
    int n_fail = 0;
    logic prev_on   = 1'b0;
    logic prev_edge = 1'b0;

    object_square dut (
        .clk          (clk),
        .reset        (reset),
        .HCount       (HCount),
        .VCount       (VCount),
        .square_select(square_select),
        .full_screen  (full_screen),
        .square_on    (square_on),
        .square_edge  (square_edge)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic exp_on, input logic exp_edge);
        n_cmp++;
        assert (square_on === exp_on) else begin
            n_fail++;
            $error("FAIL %s square_on: got %b want %b", tag, square_on, exp_on);
        end
        n_cmp++;
        assert (square_edge === exp_edge) else begin
            n_fail++;
            $error("FAIL %s square_edge: got %b want %b", tag, square_edge, exp_edge);
        end
    endtask

    // Drive a pixel, confirm outputs hold until the edge, then check the registered result.
    task automatic step(input string tag, input int h, input int v, input logic sel,
                        input logic fs, input logic exp_on, input logic exp_edge);
        HCount        = 10'(h);
        VCount        = 10'(v);
        square_select = sel;
        full_screen   = fs;
        #1;
        check({tag, "/hold"}, prev_on, prev_edge);
        @(posedge clk);
        #1;
        check(tag, exp_on, exp_edge);
        prev_on   = exp_on;
        prev_edge = exp_edge;
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 1'b0, 1'b0);
        reset = 1'b0;

        step("sq_inner",      280,  60, 1'b1, 1'b0, 1'b1, 1'b0);
        step("fs_inner",      280, 185, 1'b1, 1'b1, 1'b1, 1'b0);
        step("fs_desel",      280, 185, 1'b0, 1'b1, 1'b0, 1'b0);
        step("sq_topleft",    240,  40, 1'b1, 1'b0, 1'b1, 1'b1);
        step("sq_left_out",   239,  40, 1'b1, 1'b0, 1'b0, 1'b0);
        step("sq_botright",   399, 199, 1'b1, 1'b0, 1'b1, 1'b1);
        step("sq_right_out",  400, 199, 1'b1, 1'b0, 1'b0, 1'b0);
        step("sq_top_out",    240,  39, 1'b1, 1'b0, 1'b0, 1'b0);
        step("sq_bot_out",    300, 200, 1'b1, 1'b0, 1'b0, 1'b0);
        step("fs_origin",       0,   0, 1'b1, 1'b1, 1'b1, 1'b1);
        step("fs_corner",     639, 479, 1'b1, 1'b1, 1'b1, 1'b1);
        step("fs_hblank",     640, 100, 1'b1, 1'b1, 1'b0, 1'b0);
        step("fs_vblank",     100, 480, 1'b1, 1'b1, 1'b0, 1'b0);
        step("fs_mid",        320, 240, 1'b1, 1'b1, 1'b1, 1'b0);
        step("sq_far",         10,  10, 1'b1, 1'b0, 1'b0, 1'b0);
        step("sq_center",     300, 100, 1'b1, 1'b0, 1'b1, 1'b0);
        step("sq_ledge_in",   243, 100, 1'b1, 1'b0, 1'b1, 1'b1);
        step("sq_ledge_out",  244, 100, 1'b1, 1'b0, 1'b1, 1'b0);
        step("sq_redge_in",   396, 100, 1'b1, 1'b0, 1'b1, 1'b1);
        step("sq_redge_out",  395, 100, 1'b1, 1'b0, 1'b1, 1'b0);
        step("sq_tedge_in",   300,  43, 1'b1, 1'b0, 1'b1, 1'b1);
        step("sq_bedge_in",   300, 196, 1'b1, 1'b0, 1'b1, 1'b1);
        step("sq_bedge_out",  300, 195, 1'b1, 1'b0, 1'b1, 1'b0);
        step("sq_desel",      300, 100, 1'b0, 1'b0, 1'b0, 1'b0);
        step("sq_reselect",   300, 100, 1'b1, 1'b0, 1'b1, 1'b0);

        // Mid-cycle async reset while the object is on
        #2;
        reset = 1'b1;
        #1;
        check("async_rst", 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("rst_held", 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check("rst_release", 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("post_rst", 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, got running want finished");
        $fatal(1, "timeout");
    end

endmodule
